// File: rtl/cp0_unit.sv
// Coprocessor 0 for the M stage: SR/Cause/EPC/PRId storage, interrupt and
// exception entry, eret return, and the pipeline flush/fetch redirect.
module cp0_unit #(
    parameter logic [31:0] PRID       = 32'h2017_0001,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  cp0_addr,
    input  logic        cp0_we,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    input  logic [31:0] pcM,
    input  logic        bdM,
    input  logic        exc_validM,
    input  logic [4:0]  exc_codeM,
    input  logic [5:0]  hw_int,
    input  logic        eretM,
    output logic        flush,
    output logic        npc_sel,
    output logic [31:0] npc_cp0
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic        take;
    logic        do_eret;
    logic        do_mtc0;
    logic [31:0] pc_aligned;
    logic [31:0] epc_entry;

    assign int_req = sr_ie & ~sr_exl & (|(hw_int & sr_im));
    assign exc_req = exc_validM & ~sr_exl;
    assign take    = int_req | exc_req;
    assign do_eret = eretM & ~take;
    assign do_mtc0 = cp0_we & ~take & ~eretM;

    // A delay-slot instruction restarts at its branch, one word earlier; wraps mod 2^32.
    assign pc_aligned = pcM & 32'hFFFF_FFFC;
    assign epc_entry  = bdM ? (pc_aligned - 32'd4) : pc_aligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_im     <= 6'd0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= 6'd0;
            cause_exc <= 5'd0;
            epc       <= 32'd0;
        end else begin
            cause_ip <= hw_int;
            if (take) begin
                sr_exl    <= 1'b1;
                cause_bd  <= bdM;
                cause_exc <= int_req ? 5'd0 : exc_codeM;
                epc       <= epc_entry;
            end else if (do_eret) begin
                sr_exl <= 1'b0;
            end else if (do_mtc0) begin
                case (cp0_addr)
                    ADDR_SR: begin
                        sr_im  <= cp0_wdata[15:10];
                        sr_exl <= cp0_wdata[1];
                        sr_ie  <= cp0_wdata[0];
                    end
                    ADDR_EPC: epc <= cp0_wdata;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_addr)
            ADDR_SR:    cp0_rdata = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
            ADDR_CAUSE: cp0_rdata = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'b00};
            ADDR_EPC:   cp0_rdata = epc;
            ADDR_PRID:  cp0_rdata = PRID;
            default:    cp0_rdata = 32'd0;
        endcase
    end

    // Redirect is suppressed while reset is held so a mid-handler reset does not flush.
    assign flush   = ~rst & (take | eretM);
    assign npc_sel = flush;
    assign npc_cp0 = (take || !eretM) ? HANDLER_PC : epc;

endmodule
